// File: rtl/td4_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : td4_exec_ctrl
// Brief   : TD4-style 4-bit CPU control unit. FETCH/EXEC/FLAG sequencer that
//           drives the external adder operands and owns the architectural state.
// Revision: 1.0 - initial release
// ============================================================================
module td4_exec_ctrl (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       step_i,
    input  logic [7:0] instr_i,
    input  logic [3:0] in_port_i,
    input  logic [3:0] alu_result_i,
    input  logic       alu_flagC_i,
    output logic [3:0] pc_o,
    output logic [3:0] alu_a_o,
    output logic [3:0] alu_b_o,
    output logic [3:0] out_port_o,
    output logic [3:0] reg_a_o,
    output logic [3:0] reg_b_o,
    output logic       instr_done_o
);

    localparam logic [3:0] OP_ADD_A = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A  = 4'b0010;
    localparam logic [3:0] OP_MOV_A = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_B = 4'b0101;
    localparam logic [3:0] OP_IN_B  = 4'b0110;
    localparam logic [3:0] OP_MOV_B = 4'b0111;
    localparam logic [3:0] OP_OUT_B = 4'b1001;
    localparam logic [3:0] OP_OUT_I = 4'b1011;
    localparam logic [3:0] OP_JNC   = 4'b1110;
    localparam logic [3:0] OP_JMP   = 4'b1111;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_FLAG  = 2'd2
    } state_t;

    state_t     state_q;
    logic [7:0] ir_q;
    logic [3:0] pc_q;
    logic [3:0] pc_d;
    logic [3:0] reg_a_q;
    logic [3:0] reg_b_q;
    logic [3:0] out_q;
    logic       c_flag_q;
    logic       done_q;
    logic       wr_a;
    logic       wr_b;
    logic       wr_out;

    logic [3:0] w_op;
    logic [3:0] w_imm;
    assign w_op  = ir_q[7:4];
    assign w_imm = ir_q[3:0];

    // Operand steering and destination decode; operands stay zero outside EXEC.
    always_comb begin
        alu_a_o = 4'h0;
        alu_b_o = 4'h0;
        wr_a    = 1'b0;
        wr_b    = 1'b0;
        wr_out  = 1'b0;
        if (state_q == ST_EXEC) begin
            case (w_op)
                OP_ADD_A:  begin alu_a_o = reg_a_q;   alu_b_o = w_imm; wr_a = 1'b1; end
                OP_ADD_B:  begin alu_a_o = reg_b_q;   alu_b_o = w_imm; wr_b = 1'b1; end
                OP_MOV_A:  begin alu_b_o = w_imm;     wr_a = 1'b1; end
                OP_MOV_B:  begin alu_b_o = w_imm;     wr_b = 1'b1; end
                OP_MOV_AB: begin alu_a_o = reg_b_q;   wr_a = 1'b1; end
                OP_MOV_BA: begin alu_a_o = reg_a_q;   wr_b = 1'b1; end
                OP_IN_A:   begin alu_a_o = in_port_i; wr_a = 1'b1; end
                OP_IN_B:   begin alu_a_o = in_port_i; wr_b = 1'b1; end
                OP_OUT_B:  begin alu_a_o = reg_b_q;   alu_b_o = w_imm; wr_out = 1'b1; end
                OP_OUT_I:  begin alu_b_o = w_imm;     wr_out = 1'b1; end
                OP_JMP:    alu_b_o = w_imm;
                OP_JNC:    alu_b_o = w_imm;
                default:   ;
            endcase
        end
    end

    // c_flag holds the carry of the previously completed instruction.
    always_comb begin
        pc_d = pc_q + 4'd1;
        if (w_op == OP_JMP || (w_op == OP_JNC && !c_flag_q)) begin
            pc_d = w_imm;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_FETCH;
            ir_q     <= 8'h00;
            pc_q     <= 4'h0;
            reg_a_q  <= 4'h0;
            reg_b_q  <= 4'h0;
            out_q    <= 4'h0;
            c_flag_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    done_q <= 1'b0;
                    if (step_i) begin
                        ir_q    <= instr_i;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (wr_a)   reg_a_q <= alu_result_i;
                    if (wr_b)   reg_b_q <= alu_result_i;
                    if (wr_out) out_q   <= alu_result_i;
                    pc_q    <= pc_d;
                    done_q  <= 1'b1;
                    state_q <= ST_FLAG;
                end
                ST_FLAG: begin
                    c_flag_q <= alu_flagC_i;
                    done_q   <= 1'b0;
                    state_q  <= ST_FETCH;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

    assign pc_o         = pc_q;
    assign out_port_o   = out_q;
    assign reg_a_o      = reg_a_q;
    assign reg_b_o      = reg_b_q;
    assign instr_done_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_td4_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_td4_exec_ctrl
// Brief   : Directed bench for td4_exec_ctrl with a ROM and adder model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_td4_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       step = 1'b0;
    logic [7:0] instr;
    logic [3:0] in_port = 4'h0;
    logic [3:0] alu_result;
    logic       alu_flagC = 1'b0;
    logic [3:0] pc, alu_a, alu_b, out_port, reg_a, reg_b;
    logic       instr_done;
    logic [7:0] rom [16];
    logic       carry;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign instr = rom[pc];
    assign {carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
    always @(posedge clk) alu_flagC <= carry;

    td4_exec_ctrl dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .step_i       (step),
        .instr_i      (instr),
        .in_port_i    (in_port),
        .alu_result_i (alu_result),
        .alu_flagC_i  (alu_flagC),
        .pc_o         (pc),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .out_port_o   (out_port),
        .reg_a_o      (reg_a),
        .reg_b_o      (reg_b),
        .instr_done_o (instr_done)
    );

    typedef struct {
        string       name;
        logic [31:0] prog;
        logic [7:0]  rom15;
        logic [3:0]  inp;
        int          n;
        logic [3:0]  ea, eb, eo, epc;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        step  = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load(input logic [31:0] prog, input logic [7:0] r15);
        for (int i = 0; i < 16; i++) rom[i] = 8'h80;
        rom[0]  = prog[31:24];
        rom[1]  = prog[23:16];
        rom[2]  = prog[15:8];
        rom[3]  = prog[7:0];
        rom[15] = r15;
    endtask

    task automatic run_vec(input vec_t v);
        load(v.prog, v.rom15);
        in_port = v.inp;
        do_reset();
        step = 1'b1;
        repeat (3 * v.n) @(posedge clk);
        #1 step = 1'b0;
        chk({v.name, ".reg_a"}, {4'h0, reg_a}, {4'h0, v.ea});
        chk({v.name, ".reg_b"}, {4'h0, reg_b}, {4'h0, v.eb});
        chk({v.name, ".out"},   {4'h0, out_port}, {4'h0, v.eo});
        chk({v.name, ".pc"},    {4'h0, pc}, {4'h0, v.epc});
    endtask

    initial begin
        vecs[0] = '{"mov_add",   32'h3503_8080, 8'h80, 4'h0, 2, 4'h8, 4'h0, 4'h0, 4'h2};
        vecs[1] = '{"jnc_not",   32'h3E03_E080, 8'h80, 4'h0, 3, 4'h1, 4'h0, 4'h0, 4'h3};
        vecs[2] = '{"jnc_taken", 32'h3101_E080, 8'h80, 4'h0, 3, 4'h2, 4'h0, 4'h0, 4'h0};
        vecs[3] = '{"in_out",    32'h6092_8080, 8'h80, 4'hA, 2, 4'h0, 4'hA, 4'hC, 4'h2};
        vecs[4] = '{"moves",     32'h3740_5510, 8'h80, 4'h0, 4, 4'hC, 4'hC, 4'h0, 4'h4};
        vecs[5] = '{"out_jmp",   32'hB5F7_8080, 8'h80, 4'h0, 3, 4'h0, 4'h0, 4'h5, 4'h8};
        vecs[6] = '{"in_carry",  32'h2007_E580, 8'h80, 4'h9, 3, 4'h0, 4'h0, 4'h0, 4'h3};
        vecs[7] = '{"pc_wrap",   32'h3AFF_8080, 8'h80, 4'h0, 3, 4'hA, 4'h0, 4'h0, 4'h0};
        vecs[8] = '{"flag_clr",  32'h3F01_73E0, 8'h80, 4'h0, 4, 4'h0, 4'h3, 4'h0, 4'h0};

        load(32'h8080_8080, 8'h80);
        do_reset();
        #1;
        chk("rst.pc",    {4'h0, pc}, 8'h0);
        chk("rst.reg_a", {4'h0, reg_a}, 8'h0);
        chk("rst.reg_b", {4'h0, reg_b}, 8'h0);
        chk("rst.out",   {4'h0, out_port}, 8'h0);
        chk("rst.done",  {7'h0, instr_done}, 8'h0);
        chk("rst.alu",   {alu_a, alu_b}, 8'h00);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Cycle-accurate MOV A,5 / ADD A,3 with step held high.
        load(32'h3503_8080, 8'h80);
        do_reset();
        step = 1'b1;
        @(posedge clk); #1;
        chk("seq.exec1.alu", {alu_a, alu_b}, 8'h05);
        chk("seq.exec1.done", {7'h0, instr_done}, 8'h0);
        @(posedge clk); #1;
        chk("seq.flag1.done", {7'h0, instr_done}, 8'h1);
        chk("seq.flag1.reg_a", {4'h0, reg_a}, 8'h5);
        chk("seq.flag1.alu", {alu_a, alu_b}, 8'h00);
        @(posedge clk); #1;
        chk("seq.fetch2.done", {7'h0, instr_done}, 8'h0);
        @(posedge clk); #1;
        chk("seq.exec2.alu", {alu_a, alu_b}, 8'h53);
        @(posedge clk); #1;
        chk("seq.flag2.done", {7'h0, instr_done}, 8'h1);
        chk("seq.flag2.reg_a", {4'h0, reg_a}, 8'h8);
        step = 1'b0;
        @(posedge clk); #1;
        chk("seq.end.pc", {4'h0, pc}, 8'h2);

        // Idle in FETCH with step low.
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("idle.state", {pc, reg_a}, 8'h28);
            chk("idle.done", {3'h0, instr_done, reg_b}, 8'h00);
        end

        // in_port only matters during EXEC.
        load(32'h6080_8080, 8'h80);
        in_port = 4'h3;
        do_reset();
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        in_port = 4'hA;
        #1;
        chk("in.exec.alu_a", {4'h0, alu_a}, 8'h0A);
        @(posedge clk); #1;
        in_port = 4'hF;
        chk("in.flag.reg_b", {4'h0, reg_b}, 8'h0A);
        repeat (2) @(posedge clk);
        #1;
        chk("in.after.reg_b", {4'h0, reg_b}, 8'h0A);
        chk("in.after.pc", {4'h0, pc}, 8'h1);

        // Reset asserted during EXEC of MOV B,7.
        load(32'h3577_8080, 8'h80);
        do_reset();
        step = 1'b1;
        repeat (3) @(posedge clk);
        @(posedge clk); #1;
        chk("rstx.exec.alu", {alu_a, alu_b}, 8'h07);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step = 1'b0;
        chk("rstx.reg_b", {4'h0, reg_b}, 8'h0);
        chk("rstx.reg_a", {4'h0, reg_a}, 8'h0);
        chk("rstx.pc", {4'h0, pc}, 8'h0);
        @(posedge clk); #1;
        chk("rstx.fetch", {3'h0, instr_done, alu_b}, 8'h00);
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        chk("rstx.refetch.alu", {alu_a, alu_b}, 8'h05);
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
